// File: rtl/debouncer_multi.sv
// Multi-channel push-button debouncer: per-channel synchroniser and stability
// counter driving a clean level plus one-cycle press/release pulses.

module debouncer_lane #(
    parameter int STABLE_CYCLES = 7,
    parameter int SYNC_STAGES   = 2,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pin,
    output logic level,
    output logic press,
    output logic rel
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Any agreement with the current level discards the partial count, tick or not.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pin ^ POL};
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s;
                cnt_d   = '0;
                press_d = s;
                rel_d   = ~s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;
endmodule

module debouncer_multi #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 7,
    parameter int SYNC_STAGES   = 2,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    // "release" is a reserved word, hence the suffix.
    output logic [CHANNELS-1:0] release_o
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        debouncer_lane #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .SYNC_STAGES  (SYNC_STAGES),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_lane (
            .clk  (clk),
            .rst_n(reset),
            .tick (tick),
            .pin  (button[i]),
            .level(level[i]),
            .press(press[i]),
            .rel  (release_o[i])
        );
    end
endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: a default 4-channel instance and a
// 2-channel active-low instance, pulses checked against an expected-event queue.

module tb_debouncer_multi;
    typedef struct {
        int         cyc;
        logic [3:0] pr;
        logic [3:0] rl;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b1;
    logic [3:0] btn1 = '0;
    logic [3:0] lvl1, prs1, rel1;
    logic [1:0] btn2 = 2'b11;
    logic [1:0] lvl2, prs2, rel2;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    ev_t        q1[$];
    ev_t        q2[$];

    debouncer_multi dut1 (
        .clk(clk), .reset(reset), .tick(tick), .button(btn1),
        .level(lvl1), .press(prs1), .release_o(rel1)
    );

    debouncer_multi #(.CHANNELS(2), .STABLE_CYCLES(3), .SYNC_STAGES(2), .ACTIVE_LOW(1)) dut2 (
        .clk(clk), .reset(reset), .tick(tick), .button(btn2),
        .level(lvl2), .press(prs2), .release_o(rel2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitors: every press/release pulse must match the next queued event.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            while (q1.size() > 0 && q1[0].cyc < cyc) begin
                checks++;
                assert (0) else begin
                    failures++;
                    $error("FAIL dut1_missing_pulse observed=none expected=cyc%0d pr=%b rl=%b", q1[0].cyc, q1[0].pr, q1[0].rl);
                end
                void'(q1.pop_front());
            end
            if ((prs1 | rel1) !== 4'b0) begin
                checks++;
                if (q1.size() == 0) begin
                    assert (0) else begin
                        failures++;
                        $error("FAIL dut1_unexpected_pulse observed=cyc%0d pr=%b rl=%b expected=none", cyc, prs1, rel1);
                    end
                end else begin
                    ev_t e;
                    e = q1.pop_front();
                    assert ({cyc, prs1, rel1} === {e.cyc, e.pr, e.rl}) else begin
                        failures++;
                        $error("FAIL dut1_pulse observed=cyc%0d pr=%b rl=%b expected=cyc%0d pr=%b rl=%b", cyc, prs1, rel1, e.cyc, e.pr, e.rl);
                    end
                end
            end
            while (q2.size() > 0 && q2[0].cyc < cyc) begin
                checks++;
                assert (0) else begin
                    failures++;
                    $error("FAIL dut2_missing_pulse observed=none expected=cyc%0d pr=%b rl=%b", q2[0].cyc, q2[0].pr, q2[0].rl);
                end
                void'(q2.pop_front());
            end
            if ((prs2 | rel2) !== 2'b0) begin
                checks++;
                if (q2.size() == 0) begin
                    assert (0) else begin
                        failures++;
                        $error("FAIL dut2_unexpected_pulse observed=cyc%0d pr=%b rl=%b expected=none", cyc, prs2, rel2);
                    end
                end else begin
                    ev_t e;
                    e = q2.pop_front();
                    assert ({cyc, 2'b00, prs2, 2'b00, rel2} === {e.cyc, e.pr, e.rl}) else begin
                        failures++;
                        $error("FAIL dut2_pulse observed=cyc%0d pr=%b rl=%b expected=cyc%0d pr=%b rl=%b", cyc, prs2, rel2, e.cyc, e.pr, e.rl);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n, input bit div4);
        repeat (n) begin
            @(negedge clk);
            if (div4) tick = (cyc % 4 == 0);
        end
    endtask

    task automatic push1(input int c, input logic [3:0] pr, input logic [3:0] rl);
        ev_t e;
        e.cyc = c; e.pr = pr; e.rl = rl;
        q1.push_back(e);
    endtask

    task automatic push2(input int c, input logic [1:0] pr, input logic [1:0] rl);
        ev_t e;
        e.cyc = c; e.pr = {2'b00, pr}; e.rl = {2'b00, rl};
        q2.push_back(e);
    endtask

    initial begin
        int d;
        int e;
        int n;

        // Reset state
        step(3, 0);
        chk("rst_level1", 32'(lvl1), 32'h0);
        chk("rst_pulses1", 32'({prs1, rel1}), 32'h0);
        chk("rst_level2", 32'(lvl2), 32'h0);
        chk("rst_pulses2", 32'({prs2, rel2}), 32'h0);
        reset = 1'b1;
        step(4, 0);

        // 1: clean press on ch0, latency 2 + 7
        d = cyc; btn1[0] = 1'b1; push1(d + 9, 4'b0001, 4'b0000);
        step(8, 0);
        chk("t1_level_before", 32'(lvl1[0]), 32'h0);
        step(1, 0);
        chk("t1_level_after", 32'(lvl1[0]), 32'h1);
        step(4, 0);

        // 2: ch1 bounce with 3-cycle phases, then held
        btn1[1] = 1'b1; step(3, 0);
        btn1[1] = 1'b0; step(3, 0);
        btn1[1] = 1'b1; step(3, 0);
        btn1[1] = 1'b0; step(3, 0);
        chk("t2_level_bounce", 32'(lvl1[1]), 32'h0);
        d = cyc; btn1[1] = 1'b1; push1(d + 9, 4'b0010, 4'b0000);
        step(8, 0);
        chk("t2_level_before", 32'(lvl1[1]), 32'h0);
        step(1, 0);
        chk("t2_level_after", 32'(lvl1[1]), 32'h1);
        step(4, 0);

        // 3: ch2 press, 6-cycle low glitch, then real release
        d = cyc; btn1[2] = 1'b1; push1(d + 9, 4'b0100, 4'b0000);
        step(12, 0);
        btn1[2] = 1'b0; step(6, 0);
        btn1[2] = 1'b1; step(10, 0);
        chk("t3_glitch_level", 32'(lvl1[2]), 32'h1);
        d = cyc; btn1[2] = 1'b0; push1(d + 9, 4'b0000, 4'b0100);
        step(8, 0);
        chk("t3_level_before", 32'(lvl1[2]), 32'h1);
        step(1, 0);
        chk("t3_level_after", 32'(lvl1[2]), 32'h0);
        step(4, 0);

        // 4a: tick one cycle in four, press ch3; seventh qualified tick after sync
        d = cyc; btn1[3] = 1'b1; tick = (cyc % 4 == 0);
        n = 0; e = d + 2;
        while (n < 7) begin
            e++;
            if ((e - 1) % 4 == 0) n++;
        end
        push1(e, 4'b1000, 4'b0000);
        step(e - 1 - cyc, 1);
        chk("t4_level_before", 32'(lvl1[3]), 32'h0);
        step(1, 1);
        chk("t4_level_after", 32'(lvl1[3]), 32'h1);
        tick = 1'b1;
        step(4, 0);

        // 4b: ch0 release, count 4, freeze with tick=0, resume for the last 3
        btn1[0] = 1'b0; step(6, 0);
        tick = 1'b0; step(20, 0);
        chk("t4_frozen_level", 32'(lvl1[0]), 32'h1);
        d = cyc; tick = 1'b1; push1(d + 3, 4'b0000, 4'b0001);
        step(3, 0);
        chk("t4_resume_level", 32'(lvl1[0]), 32'h0);
        step(4, 0);

        // 4c: partial count frozen, then a bounce to match clears it
        btn1[0] = 1'b1; step(6, 0);
        tick = 1'b0; step(2, 0);
        btn1[0] = 1'b0; step(6, 0);
        d = cyc; btn1[0] = 1'b1; tick = 1'b1; push1(d + 9, 4'b0001, 4'b0000);
        step(8, 0);
        chk("t4_cleared_before", 32'(lvl1[0]), 32'h0);
        step(1, 0);
        chk("t4_cleared_after", 32'(lvl1[0]), 32'h1);
        step(4, 0);

        // 5: ch0 releasing with cnt=5, ch3 pressed, async reset
        btn1[0] = 1'b0; step(7, 0);
        chk("t5_pre_level", 32'(lvl1), 32'hB);
        reset = 1'b0;
        #1;
        chk("t5_async_level", 32'(lvl1), 32'h0);
        chk("t5_async_pulses", 32'({prs1, rel1}), 32'h0);
        step(3, 0);
        d = cyc; reset = 1'b1; push1(d + 9, 4'b1010, 4'b0000);
        step(8, 0);
        chk("t5_level_before", 32'(lvl1), 32'h0);
        step(1, 0);
        chk("t5_level_after", 32'(lvl1), 32'hA);
        step(4, 0);

        // 6: active-low 2-channel instance, latency 2 + 3
        d = cyc; btn2[0] = 1'b0; push2(d + 5, 2'b01, 2'b00);
        step(4, 0);
        chk("t6_level_before", 32'(lvl2), 32'h0);
        step(1, 0);
        chk("t6_level_after", 32'(lvl2), 32'h1);
        step(4, 0);
        d = cyc; btn2[0] = 1'b1; push2(d + 5, 2'b00, 2'b01);
        step(5, 0);
        chk("t6_release_level", 32'(lvl2), 32'h0);
        step(4, 0);
        d = cyc; btn2 = 2'b00; push2(d + 5, 2'b11, 2'b00);
        step(5, 0);
        chk("t6_both_level", 32'(lvl2), 32'h3);
        step(6, 0);

        chk("q1_drained", 32'(q1.size()), 32'h0);
        chk("q2_drained", 32'(q2.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
